// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: master IDs, request bundle and default depth for the SRAM-like arbiter
package sram_like_arbiter_pkg;
    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;
    localparam int ARB_OUTSTANDING = 4;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;
endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// arb_id_fifo: in-order FIFO of master IDs for accepted-but-unreturned transactions
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_OUTSTANDING,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic wr_en, rd_en;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    assign rd_en = pop & ~empty;
    // a full FIFO still takes a push when the same cycle frees a slot
    assign wr_en = push & (~full | rd_en);
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two-master to one-slave SRAM-like bus arbiter with in-order return routing
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the data master wins ties.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = ARB_OUTSTANDING,
    parameter int ID_W = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic [31:0] inst_addr_ok_addr,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    arb_req_t inst_f, data_f, sel_f;
    logic sel, tie_id, sel_req, accept, pop, full, empty, head_data;
    logic lock, lock_d, lock_id, lock_id_d;
    logic [ID_W-1:0] head;
    assign inst_f = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_f = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;
    always_ff @(posedge clk) begin
        if (reset) rr_last <= ARB_ID_INST;
        else if (accept) rr_last <= sel;
    end
    assign tie_id = rr_last == ARB_ID_INST ? ARB_ID_DATA : ARB_ID_INST;
`else
    assign tie_id = ARB_ID_DATA;
`endif
    // a stalled address phase stays locked to its master until the slave accepts it
    always_comb begin
        sel = lock ? lock_id : (inst_req & data_req) ? tie_id : data_req ? ARB_ID_DATA : ARB_ID_INST;
        sel_req = sel == ARB_ID_DATA ? data_req : inst_req;
        sel_f = sel == ARB_ID_DATA ? data_f : inst_f;
        mem_req = sel_req & ~full;
        accept = mem_req & mem_addr_ok;
        lock_d = accept ? 1'b0 : mem_req ? 1'b1 : lock;
        lock_id_d = (mem_req & ~mem_addr_ok) ? sel : lock_id;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lock <= 1'b0;
            lock_id <= ARB_ID_INST;
        end else begin
            lock <= lock_d;
            lock_id <= lock_id_d;
        end
    end
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = sel_f;
    assign inst_addr_ok = accept & (sel == ARB_ID_INST);
    assign data_addr_ok = accept & (sel == ARB_ID_DATA);
    assign inst_addr_ok_addr = mem_addr;
    arb_id_fifo #(.DEPTH(OUTSTANDING), .WIDTH(ID_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(accept),
        .pop(pop),
        .din(ID_W'(sel)),
        .head(head),
        .full(full),
        .empty(empty)
    );
    // returns with nothing outstanding are dropped
    assign pop = mem_data_ok & ~empty;
    assign head_data = head == ID_W'(ARB_ID_DATA);
    assign inst_data_ok = pop & ~head_data;
    assign data_data_ok = pop & head_data;
    assign inst_rdata = inst_data_ok ? mem_rdata : '0;
    assign data_rdata = data_data_ok ? mem_rdata : '0;
endmodule
